// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - access size encodings (byte / half / word)
//     - FSM state encoding
//     - width of the read-latency wait counter
//     - helper that folds the reserved size code 2'b11 onto word
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Counts WAIT cycles; READ_LATENCY is limited to 1..3 so two bits suffice.
  localparam int WAIT_CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } lsu_state_e;

  // Size code 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// -----------------------------------------------------------------------------
// lsu_lane_mux
//   Purely combinational byte-lane steering for the load/store unit.
//   Ports:
//     word        in  32  memory word as read (mem q)
//     lane        in  2   byte offset inside the word (little-endian)
//     size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD (others = word)
//     is_unsigned in  1   loads: 1 = zero-extend, 0 = sign-extend
//     wdata       in  32  store data, right-justified
//     rdata       out 32  extracted and extended load result
//     merged      out 32  word with only the addressed lane(s) replaced
//   Half accesses select the lane with lane[1]; lane[0] is ignored for them.
// -----------------------------------------------------------------------------
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    sel_byte = word[8*lane +: 8];
    sel_half = lane[1] ? word[31:16] : word[15:0];
    rdata    = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        rdata                = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
        merged[8*lane +: 8]  = wdata[7:0];
      end
      SZ_HALF: begin
        rdata                     = {{16{~is_unsigned & sel_half[15]}}, sel_half};
        merged[16*lane[1] +: 16]  = wdata[15:0];
      end
      default: begin
        rdata  = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage in front of a word-addressed synchronous RAM with a
//   whole-word write enable. Sub-word stores are done as read-modify-write.
//   Loads are extracted/extended and returned with a one-cycle rsp_valid.
//
//   Parameters:
//     ADDR_W        memory word-address width (depth = 2**ADDR_W words)
//     READ_LATENCY  edges from address capture to mem_q valid (1..3)
//
//   Ports:
//     clock, reset       rising-edge clock, synchronous active-high reset
//     req_valid/ready    request handshake (ready only when idle)
//     req_we             1 = store, 0 = load
//     req_size           00 byte, 01 half, 10 word, 11 word
//     req_unsigned       load zero-extend (1) / sign-extend (0)
//     req_addr           byte address (bits above ADDR_W+1 ignored)
//     req_wdata          right-justified store data
//     rsp_valid          one-cycle completion pulse
//     rsp_rdata          load result, 0 for stores and rejected requests
//     rsp_err            misaligned request, qualified by rsp_valid
//     mem_address/data/wren, mem_q   memory interface
//
//   Build option:
//     LSU_MISALIGN_CHECK_EN  defined: misaligned half/word requests are
//       rejected with rsp_err and no memory access. Undefined: rsp_err is 0
//       and the offending low address bits are cleared.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W       = 7,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(READ_LATENCY - 1);

  lsu_state_e state, state_next;

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_W+1:0]     addr_q;
  logic [31:0]           wbuf;      // store word: raw wdata, then merged word
  logic [31:0]           rdata_q;

  logic [1:0]        req_size_n;
  logic [ADDR_W+1:0] addr_fix;
  logic              misaligned;
  logic              accept;
  logic              wait_done;
  logic [31:0]       lane_rdata;
  logic [31:0]       lane_merged;

  // Address bits above the memory range wrap and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_size_n = norm_size(req_size);
  assign accept     = req_valid && (state == IDLE);
  assign wait_done  = (state == WAIT) && (wait_cnt == WAIT_LAST);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((req_size_n == SZ_HALF) && req_addr[0]) ||
                      ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign addr_fix   = req_addr[ADDR_W+1:0];
`else
  assign misaligned = 1'b0;
  always_comb begin
    addr_fix = req_addr[ADDR_W+1:0];
    if (req_size_n == SZ_HALF) addr_fix[0]   = 1'b0;
    if (req_size_n == SZ_WORD) addr_fix[1:0] = 2'b00;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state/output decode
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_wren   = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)                          state_next = RSP;
          else if (req_we && req_size_n == SZ_WORD) state_next = WR;
          else                                     state_next = RD;
        end
      end
      RD:   state_next = WAIT;
      WAIT: if (wait_cnt == WAIT_LAST) state_next = we_q ? WR : RSP;
      WR: begin
        mem_wren   = 1'b1;
        state_next = RSP;
      end
      RSP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, wait counter, load result and write buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wbuf     <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size_n;
        uns_q   <= req_unsigned;
        addr_q  <= addr_fix;
        wbuf    <= req_wdata;
        rdata_q <= '0;
      end

      if (state == RD)        wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + WAIT_CNT_W'(1);

      // mem_q is only guaranteed valid on the final WAIT edge.
      if (wait_done) begin
        if (we_q) wbuf    <= lane_merged;
        else      rdata_q <= lane_rdata;
      end
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clock) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= misaligned;
  end
  assign rsp_err = err_q && (state == RSP);
`else
  assign rsp_err = 1'b0;
`endif

  lsu_lane_mux u_lane_mux (
    .word        (mem_q),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wbuf),
    .rdata       (lane_rdata),
    .merged      (lane_merged)
  );

  assign mem_address = addr_q[ADDR_W+1:2];
  assign mem_data    = wbuf;
  assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit with a 128x32 synchronous RAM
//   model (read latency 1). A vector table drives requests; expected
//   responses go to a scoreboard queue that a negedge monitor pops.
//   Hand-written sequences cover busy-time req_valid and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int ADDR_W = 7;
  localparam int RL     = 1;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam logic [31:0] W3_FINAL = 32'h11AABEEF;
`else
  localparam logic [31:0] W3_FINAL = 32'h55667788;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data;
  logic              mem_wren;
  logic [31:0]       mem_q;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q)
  );

  // RAM model: registered address, unregistered q (one edge of latency).
  logic [31:0]       mem [0:127];
  logic [ADDR_W-1:0] raddr = '0;
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    raddr <= mem_address;
  end
  assign mem_q = mem[raddr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];

  // Monitor: write pulses and responses, sampled on the falling edge.
  int                wr_count = 0;
  int                rsp_count = 0;
  logic [ADDR_W-1:0] last_waddr = '0;
  always @(negedge clock) begin
    if (mem_wren) begin
      wr_count   <= wr_count + 1;
      last_waddr <= mem_address;
    end
    if (rsp_valid) begin
      rsp_count <= rsp_count + 1;
      check("rsp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  typedef struct {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       exp_rdata;
    logic              exp_err;
    int                exp_lat;
    int                exp_wr;
    logic [ADDR_W-1:0] exp_waddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int lat, input int wr, input logic [ADDR_W-1:0] waddr);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat;
    v.exp_wr = wr; v.exp_waddr = waddr;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(req_ready), 32'd1);
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(rsp_valid), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   wr0;
    wait_ready($sformatf("v%0d_ready", idx));
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat; e.start = cyc;
    sb.push_back(e);
    wr0 = wr_count;
    @(negedge clock);
    req_valid = 1'b0;
    req_wdata = $urandom;
    wait_rsp($sformatf("v%0d_rsp_seen", idx));
    check($sformatf("v%0d_wr_pulses", idx), 32'(wr_count - wr0), 32'(v.exp_wr));
    if (v.exp_wr == 1)
      check($sformatf("v%0d_wr_addr", idx), 32'(last_waddr), 32'(v.exp_waddr));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t e;
    int   wr0, rsp0;

    for (int i = 0; i < 128; i++) mem[i] = '0;

    // Table: we, size, uns, addr, wdata, exp_rdata, exp_err, latency, writes, waddr
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_000C, 32'hDEADBEEF, 32'h0, 0, 2,      1, 7'd3));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_000C, 32'h0,        32'hDEADBEEF, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_000C, 32'h80FF7F01, 32'h0, 0, 2,      1, 7'd3));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_000D, 32'h0, 32'h0000007F, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_000F, 32'h0, 32'hFFFFFF80, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0000_000E, 32'h0, 32'h000000FF, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_000E, 32'h0, 32'hFFFF80FF, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0000_000E, 32'h0, 32'h000080FF, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_000C, 32'h0, 32'h00007F01, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_000C, 32'h11223344, 32'h0, 0, 2,    1, 7'd3));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_000E, 32'hFFFFFFAA, 32'h0, 0, 3+RL, 1, 7'd3));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_000C, 32'h0, 32'h11AA3344, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0000_000C, 32'h1234BEEF, 32'h0, 0, 3+RL, 1, 7'd3));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_000C, 32'h0, 32'h11AABEEF, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0204, 32'h0CAFEF00, 32'h0, 0, 2,    1, 7'd1));
    vecs.push_back(mk(0, 2'b10, 0, 32'hFFFF_FE04, 32'h0, 32'h0CAFEF00, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0007, 32'h0, 32'h0000000C, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0005, 32'h00000080, 32'h0, 0, 3+RL, 1, 7'd1));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0004, 32'h0, 32'hFFFF8000, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h0000_000C, 32'h0, 32'h11AABEEF, 0, 2+RL, 0, 7'd0));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_000D, 32'h0, 32'h0, 1, 1, 0, 7'd0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_000E, 32'h55667788, 32'h0, 1, 1, 0, 7'd0));
`else
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_000D, 32'h0, 32'h11AABEEF, 0, 2+RL, 0, 7'd0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_000E, 32'h55667788, 32'h0, 0, 2, 1, 7'd3));
`endif
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_000C, 32'h0, W3_FINAL, 0, 2+RL, 0, 7'd0));

    // Reset state.
    repeat (2) @(negedge clock);
    check("reset_rsp_valid",   32'(rsp_valid), 32'd0);
    check("reset_rsp_err",     32'(rsp_err),   32'd0);
    check("reset_mem_wren",    32'(mem_wren),  32'd0);
    check("reset_rsp_rdata",   rsp_rdata,      32'd0);
    check("reset_mem_data",    mem_data,       32'd0);
    check("reset_mem_address", 32'(mem_address), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Busy period: a store held on req_valid during a load must be ignored.
    wait_ready("busy_ready");
    drive(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    e.rdata = W3_FINAL; e.err = 1'b0; e.lat = 2 + RL; e.start = cyc;
    sb.push_back(e);
    wr0 = wr_count;
    @(negedge clock);
    drive(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    check("busy_not_ready", 32'(req_ready), 32'd0);
    wait_rsp("busy_rsp_seen");
    req_valid = 1'b0;
    @(negedge clock);
    check("busy_no_write", 32'(wr_count - wr0), 32'd0);
    run_vec(mk(0, 2'b10, 0, 32'h0000_000C, 32'h0, W3_FINAL, 0, 2+RL, 0, 7'd0), 100);

    // Reset during WAIT of a sub-word store: nothing written, no response.
    wait_ready("rst_seq_ready");
    wr0  = wr_count;
    rsp0 = rsp_count;
    drive(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000005A);
    @(negedge clock);                    // RD
    req_valid = 1'b0;
    check("rst_seq_busy", 32'(req_ready), 32'd0);
    @(negedge clock);                    // WAIT
    reset = 1'b1;
    @(negedge clock);
    check("rst_seq_mem_wren",  32'(mem_wren),  32'd0);
    check("rst_seq_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_seq_mem_data",  mem_data,       32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_seq_ready_after", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clock);
    check("rst_seq_no_write", 32'(wr_count - wr0), 32'd0);
    check("rst_seq_no_rsp",   32'(rsp_count - rsp0), 32'd0);
    check("rst_seq_mem_word", mem[3], W3_FINAL);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage placed directly upstream of the 128x32 word-addressed data memory (`address`, `clock`, `data`, `wren`, `q`).
- Accepts CPU load/store requests with byte/half/word size, byte address and sign control.
- The memory has only a whole-word write enable, so sub-word stores are done as read-modify-write.
- Load data is extracted and extended, then returned on a one-cycle response pulse.

Parameters:
- ADDR_W, 7, memory word-address width; memory depth = 2**ADDR_W words.
- READ_LATENCY, 1, edges from the address capture to `q` valid (1..3).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and accepting.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result (0 for stores).
- rsp_err  out  1  misaligned request, qualified by rsp_valid.
- mem_address  out  ADDR_W  to memory `address`.
- mem_data  out  32  to memory `data`.
- mem_wren  out  1  to memory `wren`.
- mem_q  in  32  from memory `q`.

Behaviour:
- Reset (synchronous): state IDLE, wait counter 0; rsp_valid, rsp_err, mem_wren = 0; rsp_rdata, mem_data, mem_address = 0. req_ready = 1 from the first cycle after reset deasserts.
- Reset mid-operation:
  - Aborts the operation; no response is issued.
  - mem_wren is 0 in the cycle after the reset edge.
  - A partially merged store is never written.
- FSM states: IDLE, RD, WAIT, WR, RSP.
- Handshake:
  - req_ready = 1 only in IDLE.
  - Transfer occurs on an edge with req_valid & req_ready; all request fields are registered then.
  - One request outstanding at a time.
- Address mapping:
  - mem_address = addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo 4·2**ADDR_W bytes.
  - Lane = addr[1:0], little-endian: byte 0 = bits 7:0.
- Transitions out of IDLE on accept:
  - Word store -> WR.
  - Load or sub-word store -> RD.
  - Misaligned (with checking enabled) -> RSP.
- RD: drive mem_address, mem_wren = 0; next WAIT.
- WAIT:
  - Stays READ_LATENCY cycles, using a counter.
  - On the last WAIT edge, mem_q is captured: load -> extracted and extended into rsp_rdata; sub-word store -> merged word into a write buffer.
  - Next: RSP for a load, WR for a store.
- WR: mem_wren = 1 for exactly one cycle, with mem_address and mem_data (full word or merged word); next RSP.
- RSP: rsp_valid = 1 for one cycle; next IDLE.
- Latency, counted in cycles after the accept edge until rsp_valid is high:
  - Word store: 2.
  - Load: 2 + READ_LATENCY.
  - Sub-word store: 3 + READ_LATENCY.
  - Misaligned: 1.
- Extraction and merge:
  - Byte: lane addr[1:0].
  - Half: lane addr[1]·16.
  - Extension per req_unsigned. Merge replaces only the addressed lane; other bits come from mem_q.
- mem_wren is never asserted outside WR. req_valid is ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - Half with addr[0] = 1, or word with addr[1:0] ≠ 00, is misaligned.
  - No memory access is made; the response goes out with rsp_err = 1 and rsp_rdata = 0.
- Undefined:
  - rsp_err is tied 0.
  - Offending low address bits are cleared: half uses addr[0] = 0, word uses addr[1:0] = 00.
  - The request then proceeds normally.

Decomposition:
- Package lsu_pkg holds:
  - Size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - FSM state encoding.
  - WAIT counter width (2 bits).
- Sub-module lsu_lane_mux: purely combinational extract/extend (load) and merge (store) from {word, lane, size, unsigned, wdata}.

Test Plan:
- Word store then load (bench memory model with READ_LATENCY 1):
  - Store 0xDEADBEEF to addr 0x0C -> mem_wren high for one cycle with mem_address 3; rsp_valid 2 cycles after accept.
  - Load word 0x0C -> rsp_rdata 0xDEADBEEF, 3 cycles after accept.
- Byte loads: word 3 = 0x80FF7F01.
  - lb 0x0D -> 0x0000007F.
  - lb 0x0F -> 0xFFFFFF80.
  - lbu 0x0E -> 0x000000FF.
  - lh 0x0E -> 0xFFFF80FF.
- Sub-word store: word 3 = 0x11223344, sb 0xAA to 0x0E -> one RD, one WR; memory word 3 = 0x11AA3344; rsp_valid 4 cycles after accept.
- Wrap: word store to addr 0x204 (ADDR_W = 7) -> mem_address 1.
- Misaligned: lw at 0x0D.
  - With LSU_MISALIGN_CHECK_EN: rsp_err = 1 next cycle, no RD/WR.
  - Without it: returns word 3.
- Reset asserted during the WAIT of a sub-word store -> no mem_wren, no rsp_valid; req_ready = 1 the cycle after reset drops; memory unchanged.
